// File: rtl/rr_grant_arbiter_pkg.sv
// Shared definitions for the 4-way round-robin grant arbiter: state encodings,
// sizes and the rotating priority search.
package rr_grant_arbiter_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned HOLD_W  = 8;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_GRANT = 2'b01;
  localparam logic [1:0] ST_GAP   = 2'b10;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First asserted request starting just after 'last'; 'last' itself is checked last.
  function automatic pick_t rr_pick(input logic [IDX_W-1:0] last,
                                    input logic [NUM_REQ-1:0] req);
    pick_t            p;
    logic [IDX_W-1:0] c;
    p = '0;
    for (int k = int'(NUM_REQ); k >= 1; k--) begin
      c = last + IDX_W'(k);
      if (req[c]) begin
        p.valid = 1'b1;
        p.idx   = c;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between requesting units and the round-robin arbiter.
interface rr_grant_arbiter_if;
  import rr_grant_arbiter_pkg::*;

  logic               arb_en;
  logic [NUM_REQ-1:0] req;
  logic               gnt0;
  logic               gnt1;
  logic               gnt2;
  logic               gnt3;
  logic [IDX_W-1:0]   gnt_idx;
  logic               busy;

  modport master (
    output arb_en, req,
    input  gnt0, gnt1, gnt2, gnt3, gnt_idx, busy
  );

  modport slave (
    input  arb_en, req,
    output gnt0, gnt1, gnt2, gnt3, gnt_idx, busy
  );
endinterface

// File: rtl/rr_grant_arbiter_grant_decoder.sv
// 2:4 one-hot decoder with enable; all outputs low when enable is low.
module grant_decoder (
  input  logic addr0,
  input  logic addr1,
  input  logic enable,
  output logic out0,
  output logic out1,
  output logic out2,
  output logic out3
);

  assign out0 = enable & ~addr1 & ~addr0;
  assign out1 = enable & ~addr1 &  addr0;
  assign out2 = enable &  addr1 & ~addr0;
  assign out3 = enable &  addr1 &  addr0;

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter for 4 requesters with bounded hold time and a dead
// cycle between successive grants; grant lines are decoded from registers.
module rr_grant_arbiter
  import rr_grant_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input logic             clk,
  input logic             reset_n,
  rr_grant_arbiter_if.slave bus
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;

  logic [1:0]        state_q,   state_d;
  logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0]  last_q,    last_d;
  logic [HOLD_W-1:0] hold_q,    hold_d;
  pick_t             pick;
  logic              granting;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      gnt_idx_q <= '0;
      last_q    <= IDX_W'(NUM_REQ - 1);
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_idx_q <= gnt_idx_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
    end
  end

  // IDLE and GAP arbitrate identically; GRANT holds until release, timeout or preempt.
  always_comb begin
    state_d   = state_q;
    gnt_idx_d = gnt_idx_q;
    last_d    = last_q;
    hold_d    = hold_q;
    pick      = rr_pick(last_q, bus.req);

    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (bus.arb_en && pick.valid) begin
          state_d   = ST_GRANT;
          gnt_idx_d = pick.idx;
          hold_d    = '0;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_GRANT: begin
        hold_d = (hold_q == HOLD_SAT) ? hold_q : hold_q + HOLD_W'(1);
        if (!bus.req[gnt_idx_q] || (hold_q == HOLD_LAST) || !bus.arb_en) begin
          state_d = ST_GAP;
          last_d  = gnt_idx_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign granting    = (state_q == ST_GRANT);
  assign bus.busy    = granting;
  assign bus.gnt_idx = gnt_idx_q;

  grant_decoder u_dec (
    .addr0  (gnt_idx_q[0]),
    .addr1  (gnt_idx_q[1]),
    .enable (granting),
    .out0   (bus.gnt0),
    .out1   (bus.gnt1),
    .out2   (bus.gnt2),
    .out3   (bus.gnt3)
  );

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed checks of the round-robin arbiter: one instance at MAX_HOLD=8 and one at MAX_HOLD=2.
module tb_rr_grant_arbiter;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  rr_grant_arbiter_if if8();
  rr_grant_arbiter_if if2();

  rr_grant_arbiter #(.MAX_HOLD(8)) u_dut8 (.clk(clk), .reset_n(reset_n), .bus(if8));
  rr_grant_arbiter #(.MAX_HOLD(2)) u_dut2 (.clk(clk), .reset_n(reset_n), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {busy, gnt_idx[1:0], gnt3, gnt2, gnt1, gnt0}
  logic [6:0] obs8;
  logic [6:0] obs2;
  assign obs8 = {if8.busy, if8.gnt_idx, if8.gnt3, if8.gnt2, if8.gnt1, if8.gnt0};
  assign obs2 = {if2.busy, if2.gnt_idx, if2.gnt3, if2.gnt2, if2.gnt1, if2.gnt0};

  function automatic logic [6:0] ex(input logic b, input logic [1:0] i, input logic [3:0] g);
    return {b, i, g};
  endfunction

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed busy/idx/gnt=%b required=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] eidx;
    logic [3:0] egnt;
    logic       ebusy;
    n_checks = 0;
    n_fail   = 0;
    reset_n    = 1'b0;
    if8.arb_en = 1'b0; if8.req = 4'b0000;
    if2.arb_en = 1'b0; if2.req = 4'b0000;
    repeat (3) step();
    chk("reset8", obs8, ex(1'b0, 2'd0, 4'b0000));
    chk("reset2", obs2, ex(1'b0, 2'd0, 4'b0000));
    reset_n = 1'b1;

    // Single requester 0: grant, release, gap, idle.
    if8.arb_en = 1'b1; if8.req = 4'b0001;
    step(); chk("t1_grant", obs8, ex(1'b1, 2'd0, 4'b0001));
    if8.req = 4'b0000;
    step(); chk("t1_gap",   obs8, ex(1'b0, 2'd0, 4'b0000));
    step(); chk("t1_idle",  obs8, ex(1'b0, 2'd0, 4'b0000));
    step(); chk("t1_idle_noreq", obs8, ex(1'b0, 2'd0, 4'b0000));

    // All four requesting with MAX_HOLD=2: 0,1,2,3,0; two on, one off.
    if2.arb_en = 1'b1; if2.req = 4'b1111;
    for (int k = 0; k < 14; k++) begin
      step();
      eidx  = 2'((k / 3) % 4);
      ebusy = (k % 3) < 2;
      egnt  = ebusy ? 4'(4'b0001 << eidx) : 4'b0000;
      chk($sformatf("t2_rr_%0d", k), obs2, ex(ebusy, eidx, egnt));
      chk($sformatf("t2_excl_%0d", k), {6'd0, ($countones(obs2[3:0]) <= 1)}, 7'd1);
    end
    if2.req = 4'b0000; if2.arb_en = 1'b0;

    // Only requester 2 held with MAX_HOLD=8: eight on, one off, on again.
    if8.req = 4'b0100;
    step(); chk("t3_hold_0", obs8, ex(1'b1, 2'd2, 4'b0100));
    for (int i = 1; i < 8; i++) begin
      step(); chk($sformatf("t3_hold_%0d", i), obs8, ex(1'b1, 2'd2, 4'b0100));
    end
    step(); chk("t3_gap",     obs8, ex(1'b0, 2'd2, 4'b0000));
    step(); chk("t3_regrant", obs8, ex(1'b1, 2'd2, 4'b0100));
    if8.req = 4'b0000;
    step(); step();

    // Grant to 1 is not disturbed by req[0]; after release priority is 2,3,0.
    if8.req = 4'b0010;
    step(); chk("t4_grant1", obs8, ex(1'b1, 2'd1, 4'b0010));
    if8.req = 4'b0011;
    step(); chk("t4_keep_a", obs8, ex(1'b1, 2'd1, 4'b0010));
    step(); chk("t4_keep_b", obs8, ex(1'b1, 2'd1, 4'b0010));
    if8.req = 4'b0001;
    step(); chk("t4_gap",    obs8, ex(1'b0, 2'd1, 4'b0000));
    step(); chk("t4_grant0", obs8, ex(1'b1, 2'd0, 4'b0001));
    if8.req = 4'b0000;
    step(); step();

    // Preempt a grant to 3 by dropping arb_en; nothing granted while disabled.
    if8.req = 4'b1000;
    step(); chk("t5_grant3", obs8, ex(1'b1, 2'd3, 4'b1000));
    if8.arb_en = 1'b0; if8.req = 4'b1111;
    step(); chk("t5_preempt", obs8, ex(1'b0, 2'd3, 4'b0000));
    for (int i = 0; i < 3; i++) begin
      step(); chk($sformatf("t5_blocked_%0d", i), obs8, ex(1'b0, 2'd3, 4'b0000));
    end

    // Asynchronous reset between edges drops the grant at once.
    if8.arb_en = 1'b1;
    step(); chk("t6_grant0", obs8, ex(1'b1, 2'd0, 4'b0001));
    #3 reset_n = 1'b0;
    #1 chk("t6_async_drop", obs8, ex(1'b0, 2'd0, 4'b0000));
    @(posedge clk); #1;
    reset_n = 1'b1; if8.req = 4'b0110;
    step(); chk("t6_after_reset", obs8, ex(1'b1, 2'd1, 4'b0010));
    if8.req = 4'b0000; if8.arb_en = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
